// File: rtl/rtc_edit_pkg.sv
// Shared types and field table for the RTC field editor: FSM states, field
// indices, per-field register address and legal range, and edit-group bounds.
package rtc_edit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SCAN, ST_RD, ST_CALC, ST_WR, ST_NEXT, ST_DONE
  } state_e;

  localparam int F_SEC   = 0;
  localparam int F_MIN   = 1;
  localparam int F_HOUR  = 2;
  localparam int F_DAY   = 3;
  localparam int F_MONTH = 4;
  localparam int F_YEAR  = 5;
  localparam int F_ASEC  = 6;
  localparam int F_AMIN  = 7;
  localparam int F_AHOUR = 8;

  localparam int TBL_W  = 4;
  localparam int TBL_N  = 16;
  localparam int EDGE_N = 5;

  // Entries past F_AHOUR give extra alarm slots for larger N_FIELDS builds.
  localparam logic [7:0] FLD_ADDR [TBL_N] = '{
    8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h31, 8'h32,
    8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h3A};
  localparam logic [7:0] FLD_MIN [TBL_N] = '{
    8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0,
    8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
  localparam logic [7:0] FLD_MAX [TBL_N] = '{
    8'd59, 8'd59, 8'd23, 8'd31, 8'd12, 8'd99, 8'd59, 8'd59,
    8'd23, 8'd59, 8'd59, 8'd59, 8'd59, 8'd59, 8'd59, 8'd59};

  function automatic int unsigned grp_lo(input logic [1:0] mode);
    return (mode == 2'd2) ? F_ASEC : F_SEC;
  endfunction

  function automatic int unsigned grp_hi(input logic [1:0] mode, input int unsigned n);
    case (mode)
      2'd1:    return F_YEAR;
      2'd2:    return n - 1;
      2'd3:    return n - 1;
      default: return F_SEC;
    endcase
  endfunction

endpackage

// File: rtl/rtc_btn_edge.sv
// Registered rising-edge detector for the four buttons and the commit level;
// a pulse appears for one cycle, the cycle after the first high sample.
module rtc_btn_edge
  import rtc_edit_pkg::*;
(
  input  logic              CLK,
  input  logic              reset,
  input  logic [EDGE_N-1:0] lvl_i,
  output logic [EDGE_N-1:0] edge_o
);

  logic [EDGE_N-1:0] prev_q;
  logic [EDGE_N-1:0] edge_q;

  always_ff @(posedge CLK) begin
    if (reset) begin
      prev_q <= '0;
      edge_q <= '0;
    end else begin
      prev_q <= lvl_i;
      edge_q <= lvl_i & ~prev_q;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/rtc_field_editor.sv
// Front-panel edit controller: accumulates per-field deltas from button edits
// and commits each changed field to the RTC with a read-modify-write sequence.
module rtc_field_editor
  import rtc_edit_pkg::*;
#(
  parameter int N_FIELDS = 9,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int IDX_W    = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic [1:0]        mode,
  input  logic              commit,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rd,
  output logic              bus_wr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic [IDX_W-1:0]  cursor,
  output logic              edit_active,
  output logic              busy,
  output logic              done
);

  logic [EDGE_N-1:0] lvl;
  logic [EDGE_N-1:0] edg;

  assign lvl = {commit, btn_right, btn_left, btn_down, btn_up};

  rtc_btn_edge u_edge (
    .CLK    (CLK),
    .reset  (reset),
    .lvl_i  (lvl),
    .edge_o (edg)
  );

  state_e              state_q;
  logic [IDX_W-1:0]    f_q;
  logic [IDX_W-1:0]    cursor_q;
  logic [DATA_W-1:0]   delta_q [N_FIELDS];
  logic [DATA_W-1:0]   rd_q;
  logic [ADDR_W-1:0]   bus_addr_q;
  logic [DATA_W-1:0]   bus_wdata_q;
  logic                bus_rd_q;
  logic                bus_wr_q;
  logic                busy_q;
  logic                done_q;

  logic                up_e, dn_e, lf_e, rt_e, cm_e;
  logic                edit_en, in_grp, last_f;
  logic [IDX_W-1:0]    lo, hi, cursor_d;
  logic [TBL_W-1:0]    c_tbl, f_tbl;
  logic [DATA_W-1:0]   c_range, cur_delta, delta_up_d, delta_dn_d;
  logic [DATA_W-1:0]   f_min, f_max, f_range, f_base, result_d;
  logic [ADDR_W-1:0]   f_addr;
  logic [DATA_W:0]     sum_d;

  assign up_e = edg[0];
  assign dn_e = edg[1];
  assign lf_e = edg[2];
  assign rt_e = edg[3];
  assign cm_e = edg[4];

  always_comb begin
    lo       = IDX_W'(grp_lo(mode));
    hi       = IDX_W'(grp_hi(mode, N_FIELDS));
    edit_en  = (mode != 2'd0) && !busy_q;
    in_grp   = (cursor_q >= lo) && (cursor_q <= hi);
    last_f   = (f_q == IDX_W'(N_FIELDS - 1));

    // Mode change pulls an out-of-group cursor back to the group start.
    cursor_d = cursor_q;
    if (!in_grp)
      cursor_d = lo;
    else if (edit_en && rt_e && !lf_e)
      cursor_d = (cursor_q == hi) ? lo : cursor_q + IDX_W'(1);
    else if (edit_en && lf_e && !rt_e)
      cursor_d = (cursor_q == lo) ? hi : cursor_q - IDX_W'(1);

    c_tbl      = TBL_W'(cursor_q);
    c_range    = DATA_W'(FLD_MAX[c_tbl]) - DATA_W'(FLD_MIN[c_tbl]) + DATA_W'(1);
    cur_delta  = delta_q[cursor_q];
    delta_up_d = (cur_delta + DATA_W'(1) == c_range) ? '0 : cur_delta + DATA_W'(1);
    delta_dn_d = (cur_delta == '0) ? c_range - DATA_W'(1) : cur_delta - DATA_W'(1);

    f_tbl    = TBL_W'(f_q);
    f_addr   = ADDR_W'(FLD_ADDR[f_tbl]);
    f_min    = DATA_W'(FLD_MIN[f_tbl]);
    f_max    = DATA_W'(FLD_MAX[f_tbl]);
    f_range  = f_max - f_min + DATA_W'(1);
    f_base   = (rd_q > f_max || rd_q < f_min) ? f_min : rd_q;
    sum_d    = {1'b0, f_base} + {1'b0, delta_q[f_q]};
    result_d = (sum_d > {1'b0, f_max}) ? DATA_W'(sum_d - {1'b0, f_range}) : sum_d[DATA_W-1:0];
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      f_q         <= '0;
      cursor_q    <= '0;
      rd_q        <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_rd_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < N_FIELDS; i++) delta_q[i] <= '0;
    end else begin
      cursor_q <= cursor_d;
      if (edit_en && in_grp && up_e && !dn_e)
        delta_q[cursor_q] <= delta_up_d;
      else if (edit_en && in_grp && dn_e && !up_e)
        delta_q[cursor_q] <= delta_dn_d;

      case (state_q)
        ST_IDLE: begin
          if (cm_e) begin
            state_q <= ST_SCAN;
            f_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (delta_q[f_q] != '0) begin
            state_q    <= ST_RD;
            bus_rd_q   <= 1'b1;
            bus_addr_q <= f_addr;
          end else if (last_f) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            f_q <= f_q + IDX_W'(1);
          end
        end
        ST_RD: begin
          if (bus_ack) begin
            rd_q     <= bus_rdata;
            bus_rd_q <= 1'b0;
            state_q  <= ST_CALC;
          end
        end
        ST_CALC: begin
          bus_wdata_q <= result_d;
          bus_wr_q    <= 1'b1;
          state_q     <= ST_WR;
        end
        ST_WR: begin
          if (bus_ack) begin
            bus_wr_q     <= 1'b0;
            delta_q[f_q] <= '0;
            state_q      <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (last_f) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            f_q     <= f_q + IDX_W'(1);
            state_q <= ST_SCAN;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_addr    = bus_addr_q;
  assign bus_rd      = bus_rd_q;
  assign bus_wr      = bus_wr_q;
  assign bus_wdata   = bus_wdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign edit_active = (mode != 2'd0) && !busy_q;
  assign cursor      = (mode == 2'd0) ? '0 : cursor_q;

endmodule

// File: tb/tb_rtc_field_editor.sv
// Directed bench for rtc_field_editor with a zero-wait RTC bus responder.
module tb_rtc_field_editor;

  logic       CLK = 1'b0;
  logic       reset;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic [1:0] mode;
  logic       commit;
  logic [7:0] bus_addr, bus_wdata, bus_rdata;
  logic       bus_rd, bus_wr, bus_ack;
  logic [3:0] cursor;
  logic       edit_active, busy, done;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0] mem [256];
  int         rd_cnt, wr_cnt, other_cnt, both_cnt;
  logic [7:0] wr_addr, wr_data, exp_addr;
  bit         ack_en, force_ack;

  rtc_field_editor dut (
    .CLK(CLK), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .mode(mode), .commit(commit),
    .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .cursor(cursor), .edit_active(edit_active), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  // Bus responder: acks one cycle after a request appears, logs every transaction.
  always @(negedge CLK) begin
    if (bus_rd && bus_wr) both_cnt++;
    if (!bus_ack && ack_en && (bus_rd || bus_wr)) begin
      bus_ack = 1'b1;
      if (bus_addr != exp_addr) other_cnt++;
      if (bus_rd) begin
        bus_rdata = mem[bus_addr];
        rd_cnt++;
      end else begin
        wr_cnt++;
        wr_addr = bus_addr;
        wr_data = bus_wdata;
        mem[bus_addr] = bus_wdata;
      end
    end else begin
      bus_ack = force_ack;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(input bit u, input bit d, input bit l, input bit r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    step(1);
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    step(1);
  endtask

  task automatic clear_log(input logic [7:0] a);
    rd_cnt = 0; wr_cnt = 0; other_cnt = 0; exp_addr = a;
  endtask

  // Pulses commit and waits for done; cyc is the number of negedges from commit high to done.
  task automatic commit_wait(input int bound, output int cyc);
    cyc = 0;
    commit = 1'b1;
    for (int i = 1; i <= bound; i++) begin
      step(1);
      if (i == 1) commit = 1'b0;
      if (done) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) commit = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1; mode = 0; commit = 0; ack_en = 1; force_ack = 0;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    bus_ack = 0; bus_rdata = 0; both_cnt = 0;
    clear_log(8'h00);
    step(3);
    vec_cnt++; if (bus_addr !== 8'h00) begin err_cnt++; $display("FAIL reset_addr: got %0h want 0", bus_addr); end
    vec_cnt++; if (bus_rd !== 1'b0) begin err_cnt++; $display("FAIL reset_rd: got %0b want 0", bus_rd); end
    vec_cnt++; if (bus_wr !== 1'b0) begin err_cnt++; $display("FAIL reset_wr: got %0b want 0", bus_wr); end
    vec_cnt++; if (bus_wdata !== 8'h00) begin err_cnt++; $display("FAIL reset_wdata: got %0h want 0", bus_wdata); end
    vec_cnt++; if (cursor !== 4'd0) begin err_cnt++; $display("FAIL reset_cursor: got %0d want 0", cursor); end
    vec_cnt++; if (edit_active !== 1'b0) begin err_cnt++; $display("FAIL reset_edit: got %0b want 0", edit_active); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %0b want 0", busy); end
    vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL reset_done: got %0b want 0", done); end
    reset = 0;
    step(1);
  endtask

  task automatic test_cursor();
    logic [3:0] exp_seq [6];
    exp_seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0};
    mode = 2'd1;
    step(1);
    vec_cnt++; if (edit_active !== 1'b1) begin err_cnt++; $display("FAIL edit_active_mode1: got %0b want 1", edit_active); end
    for (int i = 0; i < 6; i++) begin
      press(0, 0, 0, 1);
      vec_cnt++; if (cursor !== exp_seq[i]) begin err_cnt++; $display("FAIL cursor_right%0d: got %0d want %0d", i, cursor, exp_seq[i]); end
    end
    press(0, 0, 1, 0);
    vec_cnt++; if (cursor !== 4'd5) begin err_cnt++; $display("FAIL cursor_left_wrap: got %0d want 5", cursor); end
    press(0, 0, 0, 1);
    vec_cnt++; if (cursor !== 4'd0) begin err_cnt++; $display("FAIL cursor_back0: got %0d want 0", cursor); end
  endtask

  task automatic test_delta();
    for (int i = 0; i < 3; i++) press(1, 0, 0, 0);
    vec_cnt++; if (dut.delta_q[0] !== 8'd3) begin err_cnt++; $display("FAIL delta_up3: got %0d want 3", dut.delta_q[0]); end
    vec_cnt++; if (rd_cnt + wr_cnt !== 0) begin err_cnt++; $display("FAIL no_commit_no_bus: got %0d want 0", rd_cnt + wr_cnt); end
  endtask

  task automatic test_commit_wrap();
    int cyc;
    mem[8'h21] = 8'd58;
    clear_log(8'h21);
    commit = 1'b1;
    step(1);
    commit = 1'b0;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL busy_early: got %0b want 0", busy); end
    step(1);
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL busy_rise: got %0b want 1", busy); end
    vec_cnt++; if (edit_active !== 1'b0) begin err_cnt++; $display("FAIL edit_while_busy: got %0b want 0", edit_active); end
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (done) begin cyc = i; break; end
    end
    vec_cnt++; if (cyc == 0) begin err_cnt++; $display("FAIL wrap_done: got timeout want done pulse"); end
    step(1);
    vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL done_width: got %0b want 0", done); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL busy_after: got %0b want 0", busy); end
    vec_cnt++; if (wr_cnt !== 1) begin err_cnt++; $display("FAIL wrap_wr_cnt: got %0d want 1", wr_cnt); end
    vec_cnt++; if (wr_addr !== 8'h21) begin err_cnt++; $display("FAIL wrap_addr: got %0h want 21", wr_addr); end
    vec_cnt++; if (wr_data !== 8'd1) begin err_cnt++; $display("FAIL wrap_data: got %0d want 1", wr_data); end
    vec_cnt++; if (dut.delta_q[0] !== 8'd0) begin err_cnt++; $display("FAIL wrap_delta_clr: got %0d want 0", dut.delta_q[0]); end
  endtask

  task automatic test_month();
    int cyc;
    for (int i = 0; i < 4; i++) press(0, 0, 0, 1);
    vec_cnt++; if (cursor !== 4'd4) begin err_cnt++; $display("FAIL month_cursor: got %0d want 4", cursor); end
    press(0, 1, 0, 0);
    vec_cnt++; if (dut.delta_q[4] !== 8'd11) begin err_cnt++; $display("FAIL month_delta: got %0d want 11", dut.delta_q[4]); end
    mem[8'h25] = 8'd1;
    clear_log(8'h25);
    commit_wait(40, cyc);
    vec_cnt++; if (cyc == 0) begin err_cnt++; $display("FAIL month_done: got timeout want done pulse"); end
    vec_cnt++; if (wr_cnt !== 1) begin err_cnt++; $display("FAIL month_wr_cnt: got %0d want 1", wr_cnt); end
    vec_cnt++; if (wr_data !== 8'd12) begin err_cnt++; $display("FAIL month_data: got %0d want 12", wr_data); end
    vec_cnt++; if (other_cnt !== 0) begin err_cnt++; $display("FAIL month_other_addr: got %0d want 0", other_cnt); end
  endtask

  task automatic test_alarm();
    int cyc;
    mode = 2'd2;
    step(1);
    vec_cnt++; if (cursor !== 4'd6) begin err_cnt++; $display("FAIL alarm_cursor_lo: got %0d want 6", cursor); end
    press(0, 1, 0, 0);
    vec_cnt++; if (dut.delta_q[6] !== 8'd59) begin err_cnt++; $display("FAIL alarm_down_wrap: got %0d want 59", dut.delta_q[6]); end
    press(0, 0, 1, 0);
    vec_cnt++; if (cursor !== 4'd8) begin err_cnt++; $display("FAIL alarm_left_wrap: got %0d want 8", cursor); end
    mem[8'h31] = 8'd200;
    clear_log(8'h31);
    commit_wait(40, cyc);
    step(1);
    vec_cnt++; if (wr_cnt !== 1) begin err_cnt++; $display("FAIL alarm_wr_cnt: got %0d want 1", wr_cnt); end
    vec_cnt++; if (wr_data !== 8'd59) begin err_cnt++; $display("FAIL alarm_oor_data: got %0d want 59", wr_data); end
    vec_cnt++; if (other_cnt !== 0) begin err_cnt++; $display("FAIL alarm_other_addr: got %0d want 0", other_cnt); end
  endtask

  task automatic test_both_and_mode0();
    mode = 2'd1;
    step(1);
    vec_cnt++; if (cursor !== 4'd0) begin err_cnt++; $display("FAIL mode1_reload: got %0d want 0", cursor); end
    press(1, 1, 0, 0);
    vec_cnt++; if (dut.delta_q[0] !== 8'd0) begin err_cnt++; $display("FAIL updown_both: got %0d want 0", dut.delta_q[0]); end
    press(0, 0, 1, 1);
    vec_cnt++; if (cursor !== 4'd0) begin err_cnt++; $display("FAIL leftright_both: got %0d want 0", cursor); end
    mode = 2'd0;
    step(1);
    vec_cnt++; if (edit_active !== 1'b0) begin err_cnt++; $display("FAIL mode0_edit: got %0b want 0", edit_active); end
    press(1, 0, 0, 0);
    vec_cnt++; if (dut.delta_q[0] !== 8'd0) begin err_cnt++; $display("FAIL mode0_up: got %0d want 0", dut.delta_q[0]); end
  endtask

  task automatic test_empty_commit();
    int cyc;
    clear_log(8'hFF);
    commit_wait(30, cyc);
    vec_cnt++; if (cyc == 0 || cyc > 11) begin err_cnt++; $display("FAIL empty_latency: got %0d want 1..11", cyc); end
    vec_cnt++; if (rd_cnt + wr_cnt !== 0) begin err_cnt++; $display("FAIL empty_bus: got %0d want 0", rd_cnt + wr_cnt); end
    step(1);
  endtask

  task automatic test_reset_mid();
    bit seen;
    mode = 2'd1;
    step(1);
    press(1, 0, 0, 0);
    ack_en = 0;
    clear_log(8'h21);
    commit = 1'b1;
    step(1);
    commit = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus_rd) begin seen = 1; break; end
    end
    vec_cnt++; if (!seen) begin err_cnt++; $display("FAIL mid_rd_seen: got timeout want bus_rd"); end
    step(1);
    reset = 1;
    step(1);
    reset = 0;
    vec_cnt++; if (bus_rd !== 1'b0) begin err_cnt++; $display("FAIL mid_rd_drop: got %0b want 0", bus_rd); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL mid_busy: got %0b want 0", busy); end
    vec_cnt++; if (dut.delta_q[0] !== 8'd0) begin err_cnt++; $display("FAIL mid_delta: got %0d want 0", dut.delta_q[0]); end
    force_ack = 1;
    step(2);
    force_ack = 0;
    step(3);
    vec_cnt++; if ({bus_rd, bus_wr, busy} !== 3'b000) begin err_cnt++; $display("FAIL late_ack: got %03b want 000", {bus_rd, bus_wr, busy}); end
    vec_cnt++; if (both_cnt !== 0) begin err_cnt++; $display("FAIL rd_wr_overlap: got %0d want 0", both_cnt); end
    ack_en = 1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    test_reset();
    test_cursor();
    test_delta();
    test_commit_wrap();
    test_month();
    test_alarm();
    test_both_and_mode0();
    test_empty_commit();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
